// File: rtl/mem_bus_arb_pkg.sv
// Shared definitions for the memory bus arbiter.
//   arb_state_t : arbiter FSM states
//   M_ICACHE / M_DCACHE : owner encodings (m0 = instruction cache, m1 = data cache)
//   DEFAULT_* : default bus geometry used as parameter defaults by the top
package mem_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } arb_state_t;

  localparam logic M_ICACHE = 1'b0;
  localparam logic M_DCACHE = 1'b1;

  localparam int DEFAULT_DATA_WIDTH = 64;
  localparam int DEFAULT_TAG_WIDTH  = 13;
  localparam int DEFAULT_BEATS      = 8;
  localparam int DEFAULT_WRITE_BIT  = 12;

endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Two-way round-robin pick (combinational).
//   req   : request vector, bit 0 = m0, bit 1 = m1
//   last  : most recent grantee
//   valid : at least one request present
//   pick  : chosen requester; on a tie the one that is not `last`
module rr_picker (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       pick
);

  assign valid = |req;
  assign pick  = (&req) ? ~last : req[1];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter giving the single memory bus to the instruction cache
// (m0) or the data cache (m1) for one whole transaction: an address beat
// followed by BEATS write-data beats or BEATS read-response beats.
//   m*_reqcyc/req/reqtag/reqack   : cache request side (reqack = address accepted)
//   m*_respcyc/resp/resptag/respack : cache response side
//   bus_*                          : shared bus pins
//   busy  : a transaction is in progress (state != IDLE)
//   owner : current or most recent grantee (0 = m0, 1 = m1)
//
// Handshake semantics: a beat transfers on a cycle where its valid (reqcyc /
// respcyc) and its acknowledge (reqack / respack) are both high; valid may be
// dropped before the acknowledge, which for the address beat abandons the grant.
// All forwarding is combinational from the registered state and owner.
module mem_bus_arbiter
  import mem_bus_arb_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int BUS_TAG_WIDTH  = DEFAULT_TAG_WIDTH,
  parameter int BEATS          = DEFAULT_BEATS,
  parameter int WRITE_BIT      = DEFAULT_WRITE_BIT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      m0_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] m0_req,
  input  logic [BUS_TAG_WIDTH-1:0]  m0_reqtag,
  output logic                      m0_reqack,
  output logic                      m0_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] m0_resp,
  output logic [BUS_TAG_WIDTH-1:0]  m0_resptag,
  input  logic                      m0_respack,
  input  logic                      m1_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] m1_req,
  input  logic [BUS_TAG_WIDTH-1:0]  m1_reqtag,
  output logic                      m1_reqack,
  output logic                      m1_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] m1_resp,
  output logic [BUS_TAG_WIDTH-1:0]  m1_resptag,
  input  logic                      m1_respack,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  output logic                      busy,
  output logic                      owner
);

  localparam int CNT_W = $clog2(BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  arb_state_t       state, state_next;
  logic             owner_q, owner_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  logic pick_valid, pick;

  // Owner-selected request-side inputs.
  logic                      sel_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] sel_req;
  logic [BUS_TAG_WIDTH-1:0]  sel_reqtag;
  logic                      sel_respack;

  // Owner-side outputs before demultiplexing to m0/m1.
  logic own_reqack;
  logic own_respcyc;

  assign sel_reqcyc  = (owner_q == M_DCACHE) ? m1_reqcyc  : m0_reqcyc;
  assign sel_req     = (owner_q == M_DCACHE) ? m1_req     : m0_req;
  assign sel_reqtag  = (owner_q == M_DCACHE) ? m1_reqtag  : m0_reqtag;
  assign sel_respack = (owner_q == M_DCACHE) ? m1_respack : m0_respack;

  rr_picker u_picker (
    .req   ({m1_reqcyc, m0_reqcyc}),
    .last  (owner_q),
    .valid (pick_valid),
    .pick  (pick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner_q <= M_DCACHE;   // so m0 wins the first tie
      cnt     <= '0;
    end else begin
      state   <= state_next;
      owner_q <= owner_next;
      cnt     <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state;
    owner_next  = owner_q;
    cnt_next    = cnt;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;
    own_reqack  = 1'b0;
    own_respcyc = 1'b0;

    case (state)
      IDLE: begin
        if (pick_valid) begin
          owner_next = pick;
          state_next = ADDR;
        end
      end
      ADDR: begin
        bus_reqcyc = sel_reqcyc;
        bus_req    = sel_req;
        bus_reqtag = sel_reqtag;
        own_reqack = bus_reqack;
        if (!sel_reqcyc) begin
          // Requester withdrew before the bus accepted: release the grant.
          state_next = IDLE;
        end else if (bus_reqack) begin
          state_next = sel_reqtag[WRITE_BIT] ? WDATA : RDATA;
          cnt_next   = '0;
        end
      end
      WDATA: begin
        // Write beats are unhandshaked: one beat per cycle.
        bus_req  = sel_req;
        cnt_next = cnt + CNT_W'(1);
        if (cnt == LAST_BEAT) state_next = IDLE;
      end
      RDATA: begin
        own_respcyc = bus_respcyc;
        bus_respack = sel_respack;
        if (bus_respcyc && sel_respack) begin
          cnt_next = cnt + CNT_W'(1);
          if (cnt == LAST_BEAT) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Route owner-side signals to the owning cache; the other sees zeros.
  always_comb begin
    m0_reqack  = 1'b0;
    m1_reqack  = 1'b0;
    m0_respcyc = 1'b0;
    m1_respcyc = 1'b0;
    m0_resp    = '0;
    m1_resp    = '0;
    m0_resptag = '0;
    m1_resptag = '0;
    if (owner_q == M_DCACHE) begin
      m1_reqack  = own_reqack;
      m1_respcyc = own_respcyc;
      if (own_respcyc) begin
        m1_resp    = bus_resp;
        m1_resptag = bus_resptag;
      end
    end else begin
      m0_reqack  = own_reqack;
      m0_respcyc = own_respcyc;
      if (own_respcyc) begin
        m0_resp    = bus_resp;
        m0_resptag = bus_resptag;
      end
    end
  end

  assign busy  = (state != IDLE);
  assign owner = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int DW = 64;
  localparam int TW = 13;

  localparam logic [3:0] E_M0_ACK  = 4'd1;
  localparam logic [3:0] E_M1_ACK  = 4'd2;
  localparam logic [3:0] E_BAD_ACK = 4'd3;
  localparam logic [3:0] E_WBEAT   = 4'd4;
  localparam logic [3:0] E_M0_RESP = 4'd5;
  localparam logic [3:0] E_M1_RESP = 4'd6;
  localparam logic [3:0] E_STRAY   = 4'd7;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_reqcyc, m1_reqcyc;
  logic [DW-1:0] m0_req, m1_req;
  logic [TW-1:0] m0_reqtag, m1_reqtag;
  logic          m0_reqack, m1_reqack;
  logic          m0_respcyc, m1_respcyc;
  logic [DW-1:0] m0_resp, m1_resp;
  logic [TW-1:0] m0_resptag, m1_resptag;
  logic          m0_respack, m1_respack;
  logic          bus_reqcyc;
  logic [DW-1:0] bus_req;
  logic [TW-1:0] bus_reqtag;
  logic          bus_reqack;
  logic          bus_respcyc;
  logic [DW-1:0] bus_resp;
  logic [TW-1:0] bus_resptag;
  logic          bus_respack;
  logic          busy;
  logic          owner;

  int tests_run = 0;
  int tests_failed = 0;
  int wbeats_left = 0;
  logic [DW+3:0] exp_q[$];

  mem_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_reqcyc(m0_reqcyc), .m0_req(m0_req), .m0_reqtag(m0_reqtag), .m0_reqack(m0_reqack),
    .m0_respcyc(m0_respcyc), .m0_resp(m0_resp), .m0_resptag(m0_resptag), .m0_respack(m0_respack),
    .m1_reqcyc(m1_reqcyc), .m1_req(m1_req), .m1_reqtag(m1_reqtag), .m1_reqack(m1_reqack),
    .m1_respcyc(m1_respcyc), .m1_resp(m1_resp), .m1_resptag(m1_resptag), .m1_respack(m1_respack),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .bus_respack(bus_respack), .busy(busy), .owner(owner)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] code, input logic [DW-1:0] data);
    exp_q.push_back({code, data});
  endtask

  task automatic sb_compare(input string name, input logic [3:0] code, input logic [DW-1:0] data);
    logic [DW+3:0] e;
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL %s: unexpected event code %0d data %0h, expected none", name, code, data);
    end else begin
      e = exp_q.pop_front();
      if (e !== {code, data}) begin
        tests_failed++;
        $display("[TB] FAIL %s: got code %0d data %0h expected code %0d data %0h",
                 name, code, data, e[DW+3:DW], e[DW-1:0]);
      end
    end
  endtask

  // Monitor: classifies bus transfers seen on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      wbeats_left = 0;
    end else begin
      if (bus_reqcyc && bus_reqack) begin
        if (m0_reqack && !m1_reqack)      sb_compare("addr_beat", E_M0_ACK, bus_req);
        else if (m1_reqack && !m0_reqack) sb_compare("addr_beat", E_M1_ACK, bus_req);
        else                              sb_compare("addr_beat", E_BAD_ACK, bus_req);
        if (bus_reqtag[12]) wbeats_left = 8;
      end else if (wbeats_left > 0) begin
        sb_compare("wdata_beat", E_WBEAT, bus_req);
        wbeats_left--;
      end
      if (bus_respcyc && bus_respack) begin
        if (m0_respcyc && !m1_respcyc)      sb_compare("resp_beat", E_M0_RESP, m0_resp);
        else if (m1_respcyc && !m0_respcyc) sb_compare("resp_beat", E_M1_RESP, m1_resp);
        else                                sb_compare("resp_beat", E_STRAY, bus_resp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs;
    m0_reqcyc = 0; m0_req = '0; m0_reqtag = '0; m0_respack = 0;
    m1_reqcyc = 0; m1_req = '0; m1_reqtag = '0; m1_respack = 0;
    bus_reqack = 0; bus_respcyc = 0; bus_resp = '0; bus_resptag = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  // Bus returns nbeats read beats base+i; optionally the owner withholds
  // respack for stall_cycles cycles on beat stall_beat.
  task automatic read_beats(input logic who, input logic [DW-1:0] base, input int nbeats,
                            input int stall_beat, input int stall_cycles);
    for (int i = 0; i < nbeats; i++) begin
      bus_respcyc = 1;
      bus_resp    = base + DW'(i);
      bus_resptag = TW'(i);
      if (i == stall_beat) begin
        m0_respack = 0;
        m1_respack = 0;
        for (int s = 0; s < stall_cycles; s++) begin
          #1;
          check("stall_bus_respack", {63'd0, bus_respack}, 64'd0);
          tick();
        end
      end
      m0_respack = (who == 1'b0);
      m1_respack = (who == 1'b1);
      push(who ? E_M1_RESP : E_M0_RESP, base + DW'(i));
      if (i == 7) check("busy_on_last_beat", {63'd0, busy}, 64'd1);
      tick();
    end
    bus_respcyc = 0; bus_resp = '0; m0_respack = 0; m1_respack = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1;
    clear_inputs();
    repeat (3) tick();
    reset = 0;

    // Reset state
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_owner", {63'd0, owner}, 64'd1);
    check("rst_bus_reqcyc", {63'd0, bus_reqcyc}, 64'd0);
    check("rst_bus_respack", {63'd0, bus_respack}, 64'd0);

    // Single read from m0
    m0_reqcyc = 1; m0_req = 64'h1000; m0_reqtag = 13'h0005;
    #1;
    check("t1_idle_before_grant", {63'd0, busy}, 64'd0);
    tick();
    check("t1_grant_latency", {63'd0, bus_reqcyc}, 64'd1);
    check("t1_owner", {63'd0, owner}, 64'd0);
    check("t1_bus_req_addr", bus_req, 64'h1000);
    tick();
    bus_reqack = 1;
    push(E_M0_ACK, 64'h1000);
    tick();
    bus_reqack = 0; m0_reqcyc = 0; m0_req = '0;
    read_beats(1'b0, 64'hA0, 8, -1, 0);
    check("t1_idle_after", {63'd0, busy}, 64'd0);

    // Simultaneous requests from reset
    do_reset();
    m0_reqcyc = 1; m0_req = 64'h3000; m0_reqtag = 13'h0;
    m1_reqcyc = 1; m1_req = 64'h4000; m1_reqtag = 13'h0;
    tick();
    check("t2_first_owner", {63'd0, owner}, 64'd0);
    bus_reqack = 1;
    push(E_M0_ACK, 64'h3000);
    #1;
    check("t2_m1_held_off", {63'd0, m1_reqack}, 64'd0);
    tick();
    bus_reqack = 0; m0_reqcyc = 0;
    read_beats(1'b0, 64'hB0, 8, -1, 0);
    check("t2_gap_idle", {63'd0, busy}, 64'd0);
    check("t2_gap_no_reqcyc", {63'd0, bus_reqcyc}, 64'd0);
    tick();
    check("t2_second_busy", {63'd0, busy}, 64'd1);
    check("t2_second_owner", {63'd0, owner}, 64'd1);
    check("t2_second_addr", bus_req, 64'h4000);
    bus_reqack = 1;
    push(E_M1_ACK, 64'h4000);
    tick();
    bus_reqack = 0; m1_reqcyc = 0;
    read_beats(1'b1, 64'hC0, 8, -1, 0);
    check("t2_idle_after", {63'd0, busy}, 64'd0);

    // Write from m1 with stray responses on the bus
    m1_reqcyc = 1; m1_req = 64'h2000; m1_reqtag = 13'h1000;
    tick();
    check("t3_owner", {63'd0, owner}, 64'd1);
    bus_reqack = 1;
    push(E_M1_ACK, 64'h2000);
    tick();
    bus_reqack = 0; m1_reqcyc = 0;
    bus_respcyc = 1; bus_resp = 64'hEE; m1_respack = 1;
    for (int i = 0; i < 8; i++) begin
      m1_req = 64'hD0 + DW'(i);
      push(E_WBEAT, 64'hD0 + DW'(i));
      if (i == 0) begin
        #1;
        check("t3_no_respack", {63'd0, bus_respack}, 64'd0);
        check("t3_no_respcyc", {63'd0, m1_respcyc}, 64'd0);
        check("t3_no_bus_reqcyc", {63'd0, bus_reqcyc}, 64'd0);
      end
      tick();
    end
    m1_req = '0; bus_respcyc = 0; bus_resp = '0; m1_respack = 0;
    check("t3_idle_after", {63'd0, busy}, 64'd0);

    // Response backpressure on beat 4
    m0_reqcyc = 1; m0_req = 64'h5000; m0_reqtag = 13'h0;
    tick();
    bus_reqack = 1;
    push(E_M0_ACK, 64'h5000);
    tick();
    bus_reqack = 0; m0_reqcyc = 0;
    read_beats(1'b0, 64'hE0, 8, 3, 3);
    check("t4_idle_after", {63'd0, busy}, 64'd0);

    // Reset during RDATA at beat 5
    m0_reqcyc = 1; m0_req = 64'h6000; m0_reqtag = 13'h0;
    tick();
    bus_reqack = 1;
    push(E_M0_ACK, 64'h6000);
    tick();
    bus_reqack = 0; m0_reqcyc = 0;
    read_beats(1'b0, 64'h60, 4, -1, 0);
    reset = 1;
    tick();
    reset = 0;
    bus_respcyc = 1; bus_resp = 64'h99; m0_respack = 1;
    #1;
    check("t5_busy", {63'd0, busy}, 64'd0);
    check("t5_owner", {63'd0, owner}, 64'd1);
    check("t5_bus_reqcyc", {63'd0, bus_reqcyc}, 64'd0);
    check("t5_no_respcyc", {63'd0, m0_respcyc}, 64'd0);
    check("t5_no_respack", {63'd0, bus_respack}, 64'd0);
    bus_respcyc = 0; bus_resp = '0; m0_respack = 0;
    m1_reqcyc = 1; m1_req = 64'h7000; m1_reqtag = 13'h0;
    tick();
    check("t5_m1_owner", {63'd0, owner}, 64'd1);
    check("t5_m1_reqcyc", {63'd0, bus_reqcyc}, 64'd1);

    // ADDR abort by m1 with m0 pending
    m0_reqcyc = 1; m0_req = 64'h8000; m0_reqtag = 13'h0;
    m1_reqcyc = 0;
    bus_reqack = 1;
    #1;
    check("t6_m0_held_off", {63'd0, m0_reqack}, 64'd0);
    check("t6_no_bus_reqcyc", {63'd0, bus_reqcyc}, 64'd0);
    tick();
    bus_reqack = 0;
    check("t6_abort_idle", {63'd0, busy}, 64'd0);
    tick();
    check("t6_m0_owner", {63'd0, owner}, 64'd0);
    check("t6_m0_addr", bus_req, 64'h8000);
    bus_reqack = 1;
    push(E_M0_ACK, 64'h8000);
    tick();
    bus_reqack = 0; m0_reqcyc = 0;
    read_beats(1'b0, 64'hF0, 8, -1, 0);
    check("t6_idle_after", {63'd0, busy}, 64'd0);

    tick();
    tick();
    check("sb_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Bound on total run time.
  initial begin
    repeat (5000) @(posedge clk);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL watchdog: got timeout expected end of stimulus");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog expired");
  end

endmodule
